// File: rtl/cv32e41s_tcm_pkg.sv
// Shared types and sizing helpers for the banked tightly-coupled memory.
package cv32e41s_tcm_pkg;

  localparam int MAX_NPORTS = 4;
  localparam int MAX_NBANKS = 8;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tcm_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } tcm_rsp_t;

  function automatic int bank_idx_w(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

  function automatic int row_w(input int mem_size, input int nbanks);
    int rows;
    rows = mem_size / (4 * nbanks);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int port_idx_w(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/cv32e41s_tcm_bank.sv
// Single-port word SRAM bank with byte write enables.
// Read latency 1; the read returns the word as it was before a same-cycle write.
module cv32e41s_tcm_bank #(
  parameter int DEPTH = 1024,
  parameter int ROW_W = 10
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      rdata_q <= mem_q[row_i];
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cv32e41s_tcm_banked.sv
// Multi-port word-interleaved TCM with per-bank round-robin arbitration.
// Response 1+OUT_REG cycles after grant; ungranted ports must hold, responses have no backpressure.
module cv32e41s_tcm_banked
  import cv32e41s_tcm_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int NBANKS   = 4,
  parameter int MEM_SIZE = 16384,
  parameter int OUT_REG  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NPORTS-1:0]    req_i,
  output logic [NPORTS-1:0]    gnt_o,
  input  logic [NPORTS-1:0]    we_i,
  input  logic [NPORTS*4-1:0]  be_i,
  input  logic [NPORTS*32-1:0] addr_i,
  input  logic [NPORTS*32-1:0] wdata_i,
  output logic [NPORTS-1:0]    rvalid_o,
  output logic [NPORTS*32-1:0] rdata_o,
  output logic [NPORTS-1:0]    err_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WW    = AW - 2;
  localparam int LB    = $clog2(NBANKS);
  localparam int BW    = bank_idx_w(NBANKS);
  localparam int RW    = row_w(MEM_SIZE, NBANKS);
  localparam int PW    = port_idx_w(NPORTS);
  localparam int DEPTH = MEM_SIZE / (4 * NBANKS);
  localparam logic [31:0] MEM_LIM = 32'(MEM_SIZE);

  tcm_req_t          req_s    [NPORTS];
  logic [WW-1:0]     word_idx [NPORTS];
  logic [BW-1:0]     bank_of  [NPORTS];
  logic [RW-1:0]     row_of   [NPORTS];
  logic [NPORTS-1:0] in_range;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      req_s[p].we    = we_i[p];
      req_s[p].be    = be_i[4*p +: 4];
      req_s[p].addr  = addr_i[32*p +: 32];
      req_s[p].wdata = wdata_i[32*p +: 32];
      word_idx[p]    = req_s[p].addr[AW-1:2];
      in_range[p]    = req_s[p].addr < MEM_LIM;
      bank_of[p]     = (NBANKS > 1) ? word_idx[p][BW-1:0] : '0;
      row_of[p]      = RW'(word_idx[p] >> LB);
    end
  end

  logic [PW-1:0]     ptr_q [NBANKS];
  logic [PW-1:0]     ptr_d [NBANKS];
  logic [PW-1:0]     sel   [NBANKS];
  logic [NBANKS-1:0] bank_req;
  logic [NPORTS-1:0] port_won;

  // Scan ports starting at the bank's pointer; the first eligible one wins.
  always_comb begin
    int idx;
    idx      = 0;
    port_won = '0;
    bank_req = '0;
    for (int b = 0; b < NBANKS; b++) begin
      sel[b]   = '0;
      ptr_d[b] = ptr_q[b];
      for (int off = 0; off < NPORTS; off++) begin
        idx = (int'(ptr_q[b]) + off) % NPORTS;
        if (!bank_req[b] && req_i[idx] && in_range[idx] && (bank_of[idx] == BW'(b))) begin
          bank_req[b]   = 1'b1;
          sel[b]        = PW'(idx);
          ptr_d[b]      = PW'((idx + 1) % NPORTS);
          port_won[idx] = 1'b1;
        end
      end
    end
  end

  // Out-of-range requests never touch a bank, so they are granted unconditionally.
  assign gnt_o = req_i & (~in_range | port_won);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NBANKS; b++) ptr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) ptr_q[b] <= ptr_d[b];
    end
  end

  logic [NBANKS-1:0] bank_we;
  logic [3:0]        bank_be    [NBANKS];
  logic [RW-1:0]     bank_row   [NBANKS];
  logic [31:0]       bank_wdata [NBANKS];
  logic [31:0]       bank_rdata [NBANKS];

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      bank_we[b]    = req_s[sel[b]].we;
      bank_be[b]    = req_s[sel[b]].be;
      bank_row[b]   = row_of[sel[b]];
      bank_wdata[b] = req_s[sel[b]].wdata;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    cv32e41s_tcm_bank #(
      .DEPTH (DEPTH),
      .ROW_W (RW)
    ) u_bank (
      .clk_i   (clk_i),
      .req_i   (bank_req[b]),
      .we_i    (bank_we[b]),
      .be_i    (bank_be[b]),
      .row_i   (bank_row[b]),
      .wdata_i (bank_wdata[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  logic [NPORTS-1:0] v1_q, we1_q, err1_q;
  logic [BW-1:0]     bank1_q [NPORTS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= '0;
      we1_q  <= '0;
      err1_q <= '0;
      for (int p = 0; p < NPORTS; p++) bank1_q[p] <= '0;
    end else begin
      v1_q   <= gnt_o;
      we1_q  <= we_i;
      err1_q <= ~in_range;
      for (int p = 0; p < NPORTS; p++) bank1_q[p] <= bank_of[p];
    end
  end

  tcm_rsp_t rsp1    [NPORTS];
  tcm_rsp_t rsp_out [NPORTS];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rsp1[p].rvalid = v1_q[p];
      rsp1[p].err    = v1_q[p] & err1_q[p];
      rsp1[p].rdata  = (v1_q[p] && !we1_q[p] && !err1_q[p]) ? bank_rdata[bank1_q[p]] : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    tcm_rsp_t rsp_q [NPORTS];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int p = 0; p < NPORTS; p++) rsp_q[p] <= '0;
      end else begin
        for (int p = 0; p < NPORTS; p++) rsp_q[p] <= rsp1[p];
      end
    end
    always_comb begin
      for (int p = 0; p < NPORTS; p++) rsp_out[p] = rsp_q[p];
    end
  end else begin : g_no_out_reg
    always_comb begin
      for (int p = 0; p < NPORTS; p++) rsp_out[p] = rsp1[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rvalid_o[p]          = rsp_out[p].rvalid;
      err_o[p]             = rsp_out[p].err;
      rdata_o[32*p +: 32]  = rsp_out[p].rdata;
    end
  end

endmodule

// File: tb/tb_cv32e41s_tcm_banked.sv
// Directed bench for cv32e41s_tcm_banked: one instance without and one with the output register, sharing stimulus.
module tb_cv32e41s_tcm_banked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we;
  logic [7:0]  be;
  logic [63:0] addr, wdata;

  logic [1:0]  gnt0, rvalid0, err0;
  logic [63:0] rdata0;
  logic [1:0]  gnt1, rvalid1, err1;
  logic [63:0] rdata1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e41s_tcm_banked #(.NPORTS(2), .NBANKS(4), .MEM_SIZE(16384), .OUT_REG(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt0), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  cv32e41s_tcm_banked #(.NPORTS(2), .NBANKS(4), .MEM_SIZE(16384), .OUT_REG(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req[p]           = r;
    we[p]            = w;
    be[4*p +: 4]     = b;
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic idle();
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_exp [3];

  initial begin
    idle();
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;

    #12;
    check_eq("rst_rvalid0", 32'(rvalid0), 32'h0);
    check_eq("rst_rvalid1", 32'(rvalid1), 32'h0);
    check_eq("rst_err0", 32'(err0), 32'h0);
    check_eq("rst_rdata0_p0", rdata0[31:0], 32'h0);
    check_eq("rst_rdata0_p1", rdata0[63:32], 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Same-bank contention: grants alternate starting at port 0.
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("rr_gnt_%0d", i), 32'(gnt0), 32'(rr_exp[i]));
      tick();
      check_eq($sformatf("rr_rvalid_%0d", i), 32'(rvalid0), 32'(rr_exp[i]));
    end
    idle();
    tick();
    check_eq("rr_drain", 32'(rvalid0), 32'h0);

    // Full write then read back.
    set_port(0, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    #1 check_eq("wr_gnt", 32'(gnt0[0]), 32'h1);
    tick();
    check_eq("wr_rvalid", 32'(rvalid0[0]), 32'h1);
    check_eq("wr_rdata", rdata0[31:0], 32'h0);
    check_eq("wr_err", 32'(err0[0]), 32'h0);
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1 check_eq("rd_gnt", 32'(gnt0[0]), 32'h1);
    tick();
    check_eq("rd_rvalid", 32'(rvalid0[0]), 32'h1);
    check_eq("rd_rdata", rdata0[31:0], 32'hDEAD_BEEF);
    check_eq("rd_err", 32'(err0[0]), 32'h0);
    idle();
    tick();
    check_eq("idle_rvalid", 32'(rvalid0), 32'h0);
    check_eq("idle_rdata", rdata0[31:0], 32'h0);

    // Different banks in parallel.
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
    #1 check_eq("par_gnt", 32'(gnt0), 32'h3);
    tick();
    check_eq("par_rvalid", 32'(rvalid0), 32'h3);
    check_eq("par_err", 32'(err0), 32'h0);
    idle();

    // Byte-enable merge on port 1, plus an all-zero enable write.
    set_port(1, 1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    tick();
    set_port(1, 1'b1, 1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD);
    tick();
    set_port(1, 1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF);
    tick();
    check_eq("be0_rvalid", 32'(rvalid0[1]), 32'h1);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    check_eq("be_merge", rdata0[63:32], 32'h11BB_33DD);
    idle();
    tick();

    // Out-of-range access alongside a legal bank-0 read.
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    #1 check_eq("oor_gnt", 32'(gnt0), 32'h3);
    tick();
    check_eq("oor_rvalid", 32'(rvalid0), 32'h3);
    check_eq("oor_err", 32'(err0), 32'h1);
    check_eq("oor_rdata", rdata0[31:0], 32'h0);
    idle();
    set_port(0, 1'b1, 1'b1, 4'hF, 32'h0000_4010, 32'h1234_5678);
    #1 check_eq("oor_wr_gnt", 32'(gnt0[0]), 32'h1);
    tick();
    check_eq("oor_wr_err", 32'(err0[0]), 32'h1);
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    tick();
    check_eq("oor_no_alias", rdata0[31:0], 32'hDEAD_BEEF);
    set_port(0, 1'b1, 1'b1, 4'hF, 32'h0000_3FFC, 32'hCAFE_F00D);
    tick();
    check_eq("top_wr_err", 32'(err0[0]), 32'h0);
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0);
    tick();
    check_eq("top_rd_rdata", rdata0[31:0], 32'hCAFE_F00D);
    check_eq("top_rd_err", 32'(err0[0]), 32'h0);
    idle();
    tick();
    tick();

    // Output-register instance: latency 2.
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1 check_eq("or_gnt", 32'(gnt1[0]), 32'h1);
    tick();
    idle();
    check_eq("or_lat1", 32'(rvalid1[0]), 32'h0);
    tick();
    check_eq("or_lat2", 32'(rvalid1[0]), 32'h1);
    check_eq("or_rdata", rdata1[31:0], 32'hDEAD_BEEF);
    tick();

    // Move both bank pointers off zero, then reset while a read is in flight.
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
    tick();
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    tick();
    idle();
    rst_n = 1'b0;
    #1 check_eq("rst_inflight", 32'(rvalid1), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("post_rst_rvalid1_%0d", i), 32'(rvalid1), 32'h0);
      check_eq($sformatf("post_rst_rvalid0_%0d", i), 32'(rvalid0), 32'h0);
    end
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1 check_eq("ptr_b0_rst", 32'(gnt1), 32'h1);
    tick();
    set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
    #1 check_eq("ptr_b1_rst", 32'(gnt1), 32'h1);
    tick();
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e41s_tcm_banked.md
CV32E41S_TCM_BANKED -- requirements
Module: cv32e41s_tcm_banked

Interface
REQ-001 Parameter NPORTS, default 2: number of independent OBI-style access ports (1..4).
REQ-002 Parameter NBANKS, default 4: word-interleaved SRAM banks, power of two (1..8).
REQ-003 Parameter MEM_SIZE, default 16384: total capacity in bytes, power of two, multiple of 4*NBANKS.
REQ-004 Parameter OUT_REG, default 0: 1 adds an output register, so read latency is 2.
REQ-005 clk_i  in  1  clock; all state on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_i  in  NPORTS  per-port access request.
REQ-008 gnt_o  out  NPORTS  per-port grant, combinational from the current requests and arbiter state.
REQ-009 we_i  in  NPORTS  per-port write enable (1 = write, 0 = read).
REQ-010 be_i  in  NPORTS x 4  per-port byte enables.
REQ-011 addr_i  in  NPORTS x 32  per-port byte address.
REQ-012 wdata_i  in  NPORTS x 32  per-port write data.
REQ-013 rvalid_o  out  NPORTS  per-port response valid.
REQ-014 rdata_o  out  NPORTS x 32  per-port read data.
REQ-015 err_o  out  NPORTS  per-port error flag, qualified by rvalid_o.

Function
REQ-016 Address decode: word index = addr_i[log2(MEM_SIZE)-1:2], bank = word index modulo NBANKS, row = word index / NBANKS; addr_i[1:0] is ignored.
REQ-017 If addr_i >= MEM_SIZE, the request is granted in the same cycle without a bank access; its response has err_o=1 and rdata_o=0, and no write occurs.
REQ-018 Each bank has a round-robin arbiter; only one in-range requester per bank is granted per cycle.
REQ-019 The priority pointer starts at port 0; after a grant it moves to the granted port +1, modulo NPORTS; it holds when nothing is granted.
REQ-020 Requests to different banks are all granted in the same cycle; no throughput is lost without a conflict.
REQ-021 A port whose request is not granted keeps req_i and its address, data and controls stable until granted; the block does not store ungranted requests.
REQ-022 A granted write updates only the bytes whose be_i bit is 1; be_i=0 changes no bytes but still produces a response.
REQ-023 rvalid_o rises exactly 1+OUT_REG cycles after the grant cycle, one response per grant, in grant order per port.
REQ-024 Read response: rdata_o holds the word as it was before any write in the same cycle; this case only arises across different cycles, because arbitration serialises same-bank accesses.
REQ-025 Write response: rdata_o=0 and err_o=0.
REQ-026 Back-to-back grants on one port give back-to-back rvalid_o cycles; there is no backpressure on responses.
REQ-027 When rvalid_o=0, rdata_o=0 and err_o=0.

Reset
REQ-028 Reset values: rvalid_o=0, err_o=0, rdata_o=0, every arbiter pointer=0, every pipeline valid=0.
REQ-029 Reset during an operation discards all in-flight responses; no rvalid_o follows deassertion without a new grant.
REQ-030 Bank contents are not reset; a read before any write returns undefined data.

Structure
REQ-031 Package cv32e41s_tcm_pkg holds: the port request struct (we, be, addr, wdata), the response struct (rvalid, rdata, err), the bank index / row width functions, and the maximum NPORTS and NBANKS constants.
REQ-032 One sub-module, cv32e41s_tcm_bank: a single-port synchronous RAM with byte write enable and read latency 1, instantiated NBANKS times.
REQ-033 The arbiter, decode and response pipeline are written inline in the top module.

Verification
REQ-034 Setup NPORTS=2, NBANKS=4, OUT_REG=0. Port0 writes 0xDEADBEEF to 0x10 with be=0xF, then reads 0x10 -> rvalid one cycle after the read grant, rdata=0xDEADBEEF, err=0.
REQ-035 Port0 reads 0x00 and port1 reads 0x04 in the same cycle -> both gnt=1, and both rvalid on the next cycle.
REQ-036 Both ports request 0x00 and 0x10 (bank 0) for 3 cycles -> grants alternate p0, p1, p0 and exactly one rvalid per cycle.
REQ-037 Word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0x5, then read -> 0x11BB33DD.
REQ-038 Read 0x4000 with MEM_SIZE=16384 -> gnt in the same cycle, then rvalid=1, err=1, rdata=0.
REQ-039 With OUT_REG=1, grant a read, then assert rst_ni low in the next cycle -> no rvalid appears after reset, and both arbiter pointers are back at 0.
